// File: rtl/skeleton_capture_buffer_if.sv
// Capture-buffer bus: skeleton trigger/sample path, host start, read-back port and status.
// master = host/skeleton side, slave = capture buffer.
interface skeleton_capture_buffer_if #(
    parameter int BW = 16,
    parameter int NW = 11
);
    logic          EN;
    logic          TRGG_START;
    logic          TRGG_DUT;
    logic [BW-1:0] DUT_DATA;
    logic          DUT_RDY;
    logic          RD_REQ;
    logic [BW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          RD_LAST;
    logic [NW-1:0] N_SAMPLES;
    logic          BUSY;
    logic          DONE;
    logic          ERR_OVF;
    logic          ERR_TOUT;

    modport master (
        output EN, TRGG_START, DUT_DATA, DUT_RDY, RD_REQ,
        input  TRGG_DUT, RD_DATA, RD_VALID, RD_LAST,
        input  N_SAMPLES, BUSY, DONE, ERR_OVF, ERR_TOUT
    );

    modport slave (
        input  EN, TRGG_START, DUT_DATA, DUT_RDY, RD_REQ,
        output TRGG_DUT, RD_DATA, RD_VALID, RD_LAST,
        output N_SAMPLES, BUSY, DONE, ERR_OVF, ERR_TOUT
    );
endinterface

// File: rtl/skeleton_capture_buffer.sv
// Triggers the ROM/LUT skeleton, captures its samples into RAM until RDY, then serves them.
// Ports: CLK_SYS, nRST (async active-low), bus (slave modport of skeleton_capture_buffer_if).
module skeleton_capture_buffer #(
    parameter int          BITWIDTH_SYS = 16,
    parameter int          DEPTH_LOG2   = 10,
    parameter int unsigned TIMEOUT_CYC  = 1000000
) (
    input  logic                      CLK_SYS,
    input  logic                      nRST,
    skeleton_capture_buffer_if.slave  bus
);
    localparam int NW = DEPTH_LOG2 + 1;
    localparam logic [NW-1:0] N_ONE = NW'(1);
    localparam logic [NW-1:0] N_DEPTH = NW'(2 ** DEPTH_LOG2);
    localparam logic [DEPTH_LOG2-1:0] W_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, ARM, CAPT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic                    trgg_dut_q, trgg_dut_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_ovf_q, err_ovf_d;
    logic                    err_tout_q, err_tout_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    rd_seen_q, rd_seen_d;
    logic [NW-1:0]           n_samples_q, n_samples_d;
    logic [NW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]             tout_cnt_q, tout_cnt_d;

    logic [BITWIDTH_SYS-1:0] mem [2**DEPTH_LOG2];
    logic [BITWIDTH_SYS-1:0] ram_rd_q;

    logic                    wr_en;
    logic                    rd_fire;
    logic                    arm;
    logic [NW-1:0]           n_inc;
    logic [31:0]             cnt_inc;

    always_comb begin
        state_d    = state_q;
        trgg_dut_d = trgg_dut_q;
        err_ovf_d  = err_ovf_q;
        err_tout_d = err_tout_q;
        rd_seen_d  = rd_seen_q;
        n_samples_d = n_samples_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tout_cnt_d = tout_cnt_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_en      = 1'b0;
        rd_fire    = 1'b0;
        arm        = 1'b0;
        n_inc      = n_samples_q + N_ONE;
        cnt_inc    = tout_cnt_q + 32'd1;

        if (bus.EN) begin
            unique case (state_q)
                IDLE: arm = bus.TRGG_START;
                ARM: begin
                    state_d    = CAPT;
                    trgg_dut_d = 1'b0;
                end
                CAPT: begin
                    wr_en       = 1'b1;
                    wr_ptr_d    = wr_ptr_q + W_ONE;
                    n_samples_d = n_inc;
                    tout_cnt_d  = cnt_inc;
                    // Exit checks see the count including this cycle's sample.
                    if (bus.DUT_RDY) begin
                        state_d = HOLD;
                    end else if (n_inc == N_DEPTH) begin
                        state_d   = HOLD;
                        err_ovf_d = 1'b1;
                    end else if (cnt_inc == TIMEOUT_CYC) begin
                        state_d    = HOLD;
                        err_tout_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.RD_REQ && (rd_ptr_q < n_samples_q)) begin
                        rd_fire    = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (rd_ptr_q == n_samples_q - N_ONE);
                        rd_ptr_d   = rd_ptr_q + N_ONE;
                        rd_seen_d  = 1'b1;
                    end
                    arm = bus.TRGG_START;
                end
                default: state_d = IDLE;
            endcase

            if (arm) begin
                state_d     = ARM;
                trgg_dut_d  = 1'b1;
                err_ovf_d   = 1'b0;
                err_tout_d  = 1'b0;
                n_samples_d = '0;
                rd_ptr_d    = '0;
                wr_ptr_d    = '0;
                tout_cnt_d  = '0;
            end
        end

        busy_d = (state_d == ARM) || (state_d == CAPT);
        done_d = (state_d == HOLD);
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            trgg_dut_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_tout_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_seen_q   <= 1'b0;
            n_samples_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            tout_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            trgg_dut_q  <= trgg_dut_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_ovf_q   <= err_ovf_d;
            err_tout_q  <= err_tout_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_seen_q   <= rd_seen_d;
            n_samples_q <= n_samples_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tout_cnt_q  <= tout_cnt_d;
        end
    end

    // Plain RAM without reset so it maps onto a block RAM.
    always_ff @(posedge CLK_SYS) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.DUT_DATA;
        end
        if (rd_fire) begin
            ram_rd_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    assign bus.TRGG_DUT  = trgg_dut_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR_OVF   = err_ovf_q;
    assign bus.ERR_TOUT  = err_tout_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.RD_LAST   = rd_last_q;
    assign bus.N_SAMPLES = n_samples_q;
    // RAM output register is not reset; show 0 until the first read.
    assign bus.RD_DATA   = rd_seen_q ? ram_rd_q : '0;
endmodule

// File: tb/tb_skeleton_capture_buffer.sv
// Bench for skeleton_capture_buffer: two instances (depth 8 / long timeout, depth 16 / timeout 5)
// share one stimulus; expectations come from a sample-list model of the capture rules.
module tb_skeleton_capture_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    skeleton_capture_buffer_if #(.BW(16), .NW(4)) ia ();
    skeleton_capture_buffer_if #(.BW(16), .NW(5)) ib ();

    assign ib.EN         = ia.EN;
    assign ib.TRGG_START = ia.TRGG_START;
    assign ib.DUT_DATA   = ia.DUT_DATA;
    assign ib.DUT_RDY    = ia.DUT_RDY;
    assign ib.RD_REQ     = ia.RD_REQ;

    skeleton_capture_buffer #(
        .BITWIDTH_SYS(16), .DEPTH_LOG2(3), .TIMEOUT_CYC(1000)
    ) dut_a (
        .CLK_SYS(clk), .nRST(rst_n), .bus(ia.slave)
    );

    skeleton_capture_buffer #(
        .BITWIDTH_SYS(16), .DEPTH_LOG2(4), .TIMEOUT_CYC(5)
    ) dut_b (
        .CLK_SYS(clk), .nRST(rst_n), .bus(ib.slave)
    );

    typedef struct {
        bit          rd_req;
        bit          exp_valid;
        logic [15:0] exp_data;
        bit          exp_last;
    } rd_vec_t;

    int nvec = 0;
    int nerr = 0;

    bit          st_en[$];
    bit          st_rdy[$];
    logic [15:0] st_dat[$];
    logic [15:0] smp[$];
    bit          smp_rdy[$];
    int          na, nb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stored samples are the enabled-cycle samples up to the first stop rule.
    task automatic model(input int depth, input int tout, output int n,
                         output bit ovf, output bit to);
        n = smp.size();
        ovf = 1'b0;
        to = 1'b0;
        for (int k = 1; k <= smp.size(); k++) begin
            if (smp_rdy[k-1]) begin
                n = k;
                return;
            end
            if (k == depth) begin
                n = k;
                ovf = 1'b1;
                return;
            end
            if (k == tout) begin
                n = k;
                to = 1'b1;
                return;
            end
        end
    endtask

    task automatic chk_rd(input string t, input logic v, input logic [15:0] d,
                          input logic l, input int j, input int n);
        if (j < n) begin
            chk({t, "_rd_valid"}, v, 1);
            chk({t, "_rd_data"}, d, smp[j]);
            chk({t, "_rd_last"}, l, (j == n - 1));
        end else begin
            chk({t, "_rd_novalid"}, v, 0);
            chk({t, "_rd_hold"}, d, smp[n-1]);
        end
    endtask

    task automatic chk_zero(input string t, input logic [31:0] v);
        chk({t, "_rst_zero"}, v, 0);
    endtask

    task automatic run_capture(input bit keep_start, input bit do_rd);
        bit oa, ta, ob, tb_;
        int k;
        smp.delete();
        smp_rdy.delete();
        foreach (st_en[i]) begin
            if (st_en[i]) begin
                smp.push_back(st_dat[i]);
                smp_rdy.push_back(st_rdy[i]);
            end
        end
        model(8, 1000, na, oa, ta);
        model(16, 5, nb, ob, tb_);

        ia.EN = 1'b1;
        ia.TRGG_START = 1'b1;
        tick();
        chk("a_trgg_arm", ia.TRGG_DUT, 1);
        chk("b_trgg_arm", ib.TRGG_DUT, 1);
        chk("a_busy_arm", ia.BUSY, 1);
        chk("a_n_arm", ia.N_SAMPLES, 0);
        chk("b_n_arm", ib.N_SAMPLES, 0);
        ia.TRGG_START = keep_start;
        tick();
        chk("a_trgg_capt", ia.TRGG_DUT, 0);
        chk("b_trgg_capt", ib.TRGG_DUT, 0);
        chk("b_busy_capt", ib.BUSY, 1);
        ia.TRGG_START = 1'b0;

        k = 0;
        foreach (st_en[i]) begin
            ia.EN = st_en[i];
            ia.DUT_DATA = st_dat[i];
            ia.DUT_RDY = st_rdy[i];
            tick();
            if (st_en[i]) k++;
            chk("a_n_run", ia.N_SAMPLES, (k < na) ? k : na);
            chk("b_n_run", ib.N_SAMPLES, (k < nb) ? k : nb);
        end
        ia.EN = 1'b1;
        ia.DUT_RDY = 1'b0;

        chk("a_done", ia.DONE, 1);
        chk("a_busy_end", ia.BUSY, 0);
        chk("a_ovf", ia.ERR_OVF, oa);
        chk("a_tout", ia.ERR_TOUT, ta);
        chk("b_done", ib.DONE, 1);
        chk("b_busy_end", ib.BUSY, 0);
        chk("b_ovf", ib.ERR_OVF, ob);
        chk("b_tout", ib.ERR_TOUT, tb_);

        if (do_rd) begin
            for (int j = 0; j < 9; j++) begin
                ia.RD_REQ = 1'b1;
                tick();
                chk_rd("a", ia.RD_VALID, ia.RD_DATA, ia.RD_LAST, j, na);
                chk_rd("b", ib.RD_VALID, ib.RD_DATA, ib.RD_LAST, j, nb);
            end
            ia.RD_REQ = 1'b0;
            tick();
            chk("a_rd_idle", ia.RD_VALID, 0);
            chk("b_rd_idle", ib.RD_VALID, 0);
        end
    endtask

    task automatic clr_stim();
        st_en.delete();
        st_rdy.delete();
        st_dat.delete();
    endtask

    task automatic push(input bit e, input logic [15:0] d, input bit r);
        st_en.push_back(e);
        st_dat.push_back(d);
        st_rdy.push_back(r);
    endtask

    task automatic gen_random();
        int r, k;
        bit e;
        clr_stim();
        r = $urandom_range(1, 12);
        k = 0;
        while (k < 10) begin
            e = ($urandom_range(0, 3) != 0);
            if (e) k++;
            push(e, 16'($urandom), e ? (k == r) : 1'($urandom));
        end
    endtask

    rd_vec_t t1_rd[10];

    initial begin
        for (int i = 0; i < 10; i++) begin
            t1_rd[i].rd_req    = (i < 9);
            t1_rd[i].exp_valid = (i < 8);
            t1_rd[i].exp_data  = (i < 8) ? 16'(i + 1) : 16'd8;
            t1_rd[i].exp_last  = (i == 7);
        end

        ia.EN = 1'b0;
        ia.TRGG_START = 1'b0;
        ia.DUT_DATA = '0;
        ia.DUT_RDY = 1'b0;
        ia.RD_REQ = 1'b0;

        #12;
        chk_zero("a_trgg", ia.TRGG_DUT);
        chk_zero("a_busy", ia.BUSY);
        chk_zero("a_done", ia.DONE);
        chk_zero("a_n", ia.N_SAMPLES);
        chk_zero("b_n", ib.N_SAMPLES);
        chk_zero("a_rdv", ia.RD_VALID);
        chk_zero("a_rdd", ia.RD_DATA);
        rst_n = 1'b1;
        tick();

        // T1: samples 1..8, RDY on the 8th; table-driven read-back.
        clr_stim();
        for (int i = 1; i <= 8; i++) push(1'b1, 16'(i), (i == 8));
        run_capture(1'b0, 1'b0);
        chk("t1_a_n", ia.N_SAMPLES, 8);
        for (int i = 0; i < 10; i++) begin
            ia.RD_REQ = t1_rd[i].rd_req;
            tick();
            chk("t1_a_valid", ia.RD_VALID, t1_rd[i].exp_valid);
            chk("t1_a_data", ia.RD_DATA, t1_rd[i].exp_data);
            if (t1_rd[i].exp_valid) chk("t1_a_last", ia.RD_LAST, t1_rd[i].exp_last);
            chk_rd("t1_b", ib.RD_VALID, ib.RD_DATA, ib.RD_LAST, (i < 9) ? i : 99, nb);
        end
        ia.RD_REQ = 1'b0;

        // T4: retrigger from HOLD clears status.
        ia.TRGG_START = 1'b1;
        tick();
        chk("t4_a_busy", ia.BUSY, 1);
        chk("t4_a_done", ia.DONE, 0);
        chk("t4_a_n", ia.N_SAMPLES, 0);
        chk("t4_b_tout", ib.ERR_TOUT, 0);
        chk("t4_a_trgg", ia.TRGG_DUT, 1);
        ia.TRGG_START = 1'b0;
        tick();

        // T6: reset in the middle of a capture.
        for (int i = 0; i < 3; i++) begin
            ia.DUT_DATA = 16'h0A00 + 16'(i);
            tick();
        end
        chk("t6_a_n_pre", ia.N_SAMPLES, 3);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("t6_a_busy", ia.BUSY);
        chk_zero("t6_a_n", ia.N_SAMPLES);
        chk_zero("t6_b_n", ib.N_SAMPLES);
        chk_zero("t6_a_done", ia.DONE);
        chk_zero("t6_a_rdd", ia.RD_DATA);
        chk_zero("t6_a_trgg", ia.TRGG_DUT);
        chk_zero("t6_b_tout", ib.ERR_TOUT);
        #1 rst_n = 1'b1;
        tick();
        gen_random();
        run_capture(1'b1, 1'b1);

        // T2: overflow without RDY, then RDY exactly on the DEPTH-th sample.
        clr_stim();
        for (int i = 0; i < 12; i++) push(1'b1, 16'h2000 + 16'(i), 1'b0);
        run_capture(1'b0, 1'b1);
        clr_stim();
        for (int i = 1; i <= 8; i++) push(1'b1, 16'h3000 + 16'(i), (i == 8));
        run_capture(1'b0, 1'b1);

        // T5: three disabled cycles in the middle; RDY on the 6th enabled sample.
        clr_stim();
        for (int i = 1; i <= 3; i++) push(1'b1, 16'h5000 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) push(1'b0, 16'hDEAD, 1'b1);
        for (int i = 4; i <= 6; i++) push(1'b1, 16'h5000 + 16'(i), (i == 6));
        run_capture(1'b0, 1'b1);
        chk("t5_a_n", ia.N_SAMPLES, 6);

        for (int s = 0; s < 6; s++) begin
            gen_random();
            run_capture(s[0], 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
